// File: rtl/md_unit_if.sv
// Signal bundle between the E-stage pipeline and the multiply/divide unit.
// The slave side is md_unit; the master side is the pipeline, or a bench.
interface md_unit_if;
   logic        mult_E;
   logic        div_E;
   logic        mthi_E;
   logic        mtlo_E;
   logic [31:0] rs_E;
   logic [31:0] rt_E;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        md_stall;

   modport master (
      output mult_E, div_E, mthi_E, mtlo_E, rs_E, rt_E,
      input  hi, lo, busy, md_stall
   );

   modport slave (
      input  mult_E, div_E, mthi_E, mtlo_E, rs_E, rt_E,
      output hi, lo, busy, md_stall
   );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. It owns HI/LO and computes the result when the operation starts.
// The result is held back for a fixed number of busy cycles, to model the latency of a real multiplier or divider.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   md_unit_if.slave  bus
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_count;
   logic          r_pend_valid;
   logic [31:0]   r_pend_hi;
   logic [31:0]   r_pend_lo;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_start;
   logic          w_busy;
   logic          w_stall;
   logic          w_last;

   logic [63:0]   w_prod;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic [31:0]   w_b_safe;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_quot;
   logic [31:0]   w_rem;

   // Sign-extend both operands to 64 bits. The low 64 bits of the unsigned
   // product then equal the signed 32x32 product.
   assign w_prod = {{32{bus.rs_E[31]}}, bus.rs_E} * {{32{bus.rt_E[31]}}, bus.rt_E};

   // The divide works on magnitudes, so 0x80000000 / -1 wraps back to 0x80000000
   // instead of overflowing. A zero divisor is replaced by 1 to keep the datapath
   // well defined. That result is never committed.
   assign w_a_neg  = bus.rs_E[31];
   assign w_b_neg  = bus.rt_E[31];
   assign w_a_mag  = w_a_neg ? (32'd0 - bus.rs_E) : bus.rs_E;
   assign w_b_mag  = w_b_neg ? (32'd0 - bus.rt_E) : bus.rt_E;
   assign w_b_safe = (bus.rt_E == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_safe;
   assign w_r_mag  = w_a_mag % w_b_safe;
   assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   assign w_last   = (r_count == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_RUN;
         S_RUN:   if (w_last)  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy  = (r_state == S_RUN);
      w_start = (r_state == S_IDLE) && (bus.mult_E || bus.div_E);
      w_stall = w_busy || w_start;
   end

   // mult takes priority over div. mthi/mtlo write only when the unit is idle
   // and no operation is starting in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count      <= '0;
         r_pend_valid <= 1'b0;
         r_pend_hi    <= 32'd0;
         r_pend_lo    <= 32'd0;
         r_hi         <= 32'd0;
         r_lo         <= 32'd0;
      end else if (w_start) begin
         if (bus.mult_E) begin
            r_pend_hi    <= w_prod[63:32];
            r_pend_lo    <= w_prod[31:0];
            r_pend_valid <= 1'b1;
            r_count      <= CW'(MULT_CYCLES);
         end else begin
            r_pend_hi    <= w_rem;
            r_pend_lo    <= w_quot;
            r_pend_valid <= (bus.rt_E != 32'd0);
            r_count      <= CW'(DIV_CYCLES);
         end
      end else if (w_busy) begin
         r_count <= r_count - CW'(1);
         if (w_last && r_pend_valid) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else begin
         if (bus.mthi_E) r_hi <= bus.rs_E;
         if (bus.mtlo_E) r_lo <= bus.rs_E;
      end
   end

   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
   assign bus.busy     = w_busy;
   assign bus.md_stall = w_stall;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit. Directed operations push their expected HI/LO into a queue.
// A monitor pops and compares on every commit, which it sees as busy falling without reset.
module tb_md_unit;
   logic clk;
   logic reset;
   md_unit_if u_if();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      u_if.mult_E = 1'b0;
      u_if.div_E  = 1'b0;
      u_if.mthi_E = 1'b0;
      u_if.mtlo_E = 1'b0;
      u_if.rs_E   = 32'd0;
      u_if.rt_E   = 32'd0;
   endtask

   // Commit monitor. It samples shortly after each rising edge, away from the
   // stimulus, which is driven on the falling edge.
   initial begin
      logic prev_busy;
      logic [63:0] e;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            prev_busy = 1'b0;
         end else begin
            if (prev_busy && !u_if.busy) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL commit_unexpected: got hi=%h lo=%h expected no commit", u_if.hi, u_if.lo);
               end else begin
                  e = exp_q.pop_front();
                  chk("commit_hi", u_if.hi, e[63:32]);
                  chk("commit_lo", u_if.lo, e[31:0]);
                  $display("commit: hi=%h lo=%h (expected hi=%h lo=%h)", u_if.hi, u_if.lo, e[63:32], e[31:0]);
               end
            end
            prev_busy = u_if.busy;
         end
      end
   end

   // Starts one mult/div and tracks it until busy drops. If inj is set, it pulses
   // div_E+mtlo_E on the second busy cycle; that pulse must have no effect.
   task automatic run_op(input string nm, input logic m, input logic d, input logic mth,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int cycles, input logic inj);
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int n;
      bit done;
      @(negedge clk);
      old_hi = u_if.hi;
      old_lo = u_if.lo;
      u_if.mult_E = m;
      u_if.div_E  = d;
      u_if.mthi_E = mth;
      u_if.rs_E   = rs;
      u_if.rt_E   = rt;
      #1;
      chk({nm, "_stall_start"}, 32'(u_if.md_stall), 32'd1);
      exp_q.push_back({exp_hi, exp_lo});
      n = 0;
      done = 1'b0;
      for (int g = 0; g < 40 && !done; g++) begin
         @(negedge clk);
         if (u_if.busy) begin
            n++;
            chk({nm, "_hold_hi"}, u_if.hi, old_hi);
            chk({nm, "_hold_lo"}, u_if.lo, old_lo);
            chk({nm, "_stall_busy"}, 32'(u_if.md_stall), 32'd1);
            clear_inputs();
            if (inj && n == 2) begin
               u_if.div_E  = 1'b1;
               u_if.mtlo_E = 1'b1;
               u_if.rs_E   = 32'h55;
               u_if.rt_E   = 32'h7;
            end
         end else begin
            done = 1'b1;
         end
      end
      clear_inputs();
      chk({nm, "_busy_cycles"}, 32'(n), 32'(cycles));
      chk({nm, "_stall_after"}, 32'(u_if.md_stall), 32'd0);
      $display("op %s: rs=%h rt=%h busy_cycles=%0d hi=%h lo=%h", nm, rs, rt, n, u_if.hi, u_if.lo);
   endtask

   task automatic move_to(input logic mth, input logic mtl, input logic [31:0] rs,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      @(negedge clk);
      u_if.mthi_E = mth;
      u_if.mtlo_E = mtl;
      u_if.rs_E   = rs;
      #1;
      chk("mt_stall", 32'(u_if.md_stall), 32'd0);
      @(negedge clk);
      clear_inputs();
      chk("mt_hi", u_if.hi, exp_hi);
      chk("mt_lo", u_if.lo, exp_lo);
      chk("mt_stall_after", 32'(u_if.md_stall), 32'd0);
      $display("move: mthi=%0b mtlo=%0b rs=%h hi=%h lo=%h", mth, mtl, rs, u_if.hi, u_if.lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_hi", u_if.hi, 32'd0);
      chk("rst_lo", u_if.lo, 32'd0);
      chk("rst_busy", 32'(u_if.busy), 32'd0);
      chk("rst_stall", 32'(u_if.md_stall), 32'd0);

      move_to(1'b1, 1'b0, 32'h0000ABCD, 32'h0000ABCD, 32'd0);

      run_op("mult_neg", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000003,
             32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);
      run_op("div_neg", 1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002,
             32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
      run_op("div_ovf", 1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000, 10, 1'b0);

      move_to(1'b1, 1'b1, 32'h00000011, 32'h00000011, 32'h00000011);
      move_to(1'b0, 1'b1, 32'h00000022, 32'h00000011, 32'h00000022);
      run_op("div_zero", 1'b0, 1'b1, 1'b0, 32'h00000005, 32'h00000000,
             32'h00000011, 32'h00000022, 10, 1'b0);

      run_op("mult_div", 1'b1, 1'b1, 1'b0, 32'h00000006, 32'h00000003,
             32'h00000000, 32'h00000012, 5, 1'b1);
      run_op("mult_mthi", 1'b1, 1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFF9, 5, 1'b0);

      // Assert reset while the counter holds 3, after three busy edges.
      @(negedge clk);
      u_if.mult_E = 1'b1;
      u_if.rs_E   = 32'h00000003;
      u_if.rt_E   = 32'h00000004;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", 32'(u_if.busy), 32'd0);
      chk("midrst_hi", u_if.hi, 32'd0);
      chk("midrst_lo", u_if.lo, 32'd0);
      $display("reset mid-run: busy=%0b hi=%h lo=%h", u_if.busy, u_if.hi, u_if.lo);
      repeat (12) @(negedge clk);
      chk("midrst_late_busy", 32'(u_if.busy), 32'd0);
      chk("midrst_late_lo", u_if.lo, 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
